// File: rtl/hdd_spi_host_if.sv
// hdd_spi_host_if
//   SPI slave (mode 0, MSB first) through which the ARM controller services
//   IDE commands raised by the Gayle block. The first byte of each frame is a
//   command; the rest of the frame moves task-file bytes, the status byte or
//   sector-FIFO words. Everything runs on clk; the SPI pins are oversampled.
//
//   Ports
//     clk, reset            system clock, async active-low reset
//     sck, sdi, scs, sdo    SPI pins (scs active low, one low period = frame)
//     hdd_cmd_req           Gayle command pending
//     hdd_dat_req           Gayle FIFO holds data for the host
//     hdd_data_in[15:0]     task-file byte in [7:0], FIFO word when addr=0
//     hdd_addr[2:0]         task-file / FIFO select
//     hdd_data_out[15:0]    data to Gayle
//     hdd_wr                task-file write strobe
//     hdd_status_wr         status write strobe
//     hdd_data_wr           FIFO write strobe
//     hdd_data_rd           FIFO advance strobe
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   S_IDLE    | scs high, everything cleared
//   S_CMD     | shifting in the command byte
//   S_TFR_RD  | returning task-file registers 1..7
//   S_TFR_WR  | writing task-file registers 1..7
//   S_STAT_WR | receiving the status byte
//   S_DATA_WR | streaming words into the sector FIFO
//   S_DATA_RD | streaming words out of the sector FIFO
//   S_STAT_RD | returning {cmd_req, dat_req, 6'b0}
//   S_IGNORE  | frame finished or unknown command, wait for scs

module hdd_spi_host_if #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_WORDS   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        sdi,
  output logic        sdo,
  input  logic        scs,
  input  logic        hdd_cmd_req,
  input  logic        hdd_dat_req,
  input  logic [15:0] hdd_data_in,
  output logic [2:0]  hdd_addr,
  output logic [15:0] hdd_data_out,
  output logic        hdd_wr,
  output logic        hdd_status_wr,
  output logic        hdd_data_wr,
  output logic        hdd_data_rd
);

  localparam logic [8:0] MAX_W = 9'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_TFR_RD, S_TFR_WR, S_STAT_WR,
    S_DATA_WR, S_DATA_RD, S_STAT_RD, S_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, scs_sync;
  logic sck_d;
  logic sck_s, sdi_s, scs_s;
  logic sck_rise, sck_fall;

  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  rx_byte;
  logic [2:0]  tfr_cnt;
  logic        half;
  logic [7:0]  hi_byte;
  logic [8:0]  word_cnt;
  logic        load_pend;
  logic [15:0] tx_sr;
  logic        wr_pend, stat_pend, dwr_pend, rd_pend;

  // output-comb decode
  logic        live, byte_done, words_left;
  logic        do_tfr_wr, do_stat_wr, do_word_wr, arm_load, do_load, do_shift, do_fifo_rd;
  logic [15:0] tx_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      scs_sync <= '1;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      scs_sync <= {scs_sync[SYNC_STAGES-2:0], scs};
      sck_d    <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign scs_s    = scs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign rx_byte  = {rx_sr, sdi_s};

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    if (scs_s) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_CMD;
        S_CMD: if (byte_done) begin
          case (rx_byte)
            8'h10:   state_nxt = S_TFR_RD;
            8'h11:   state_nxt = S_TFR_WR;
            8'h12:   state_nxt = S_STAT_WR;
            8'h13:   state_nxt = S_DATA_WR;
            8'h14:   state_nxt = S_DATA_RD;
            8'h15:   state_nxt = S_STAT_RD;
            default: state_nxt = S_IGNORE;
          endcase
        end
        S_TFR_RD, S_TFR_WR:   if (byte_done && tfr_cnt == 3'd6) state_nxt = S_IGNORE;
        S_STAT_WR, S_STAT_RD: if (byte_done) state_nxt = S_IGNORE;
        default: ;
      endcase
    end
  end

  // output/action decode
  always_comb begin
    live       = ~scs_s && (state != S_IDLE);
    byte_done  = live && sck_rise && (bit_cnt == 3'd7);
    words_left = word_cnt < MAX_W;
    do_tfr_wr  = byte_done && (state == S_TFR_WR);
    do_stat_wr = byte_done && (state == S_STAT_WR);
    do_word_wr = byte_done && (state == S_DATA_WR) && half && words_left;
    // a response slot starts at the fall that follows the arming rise
    arm_load   = byte_done &&
                 (((state == S_CMD) && (rx_byte == 8'h10 || rx_byte == 8'h14 || rx_byte == 8'h15)) ||
                  ((state == S_TFR_RD) && (tfr_cnt != 3'd6)) ||
                  ((state == S_DATA_RD) && half));
    do_load    = live && sck_fall && load_pend;
    do_shift   = live && sck_fall && !load_pend &&
                 (state == S_TFR_RD || state == S_DATA_RD || state == S_STAT_RD);
    do_fifo_rd = do_load && (state == S_DATA_RD) && words_left;
    tx_word    = '0;
    case (state)
      S_TFR_RD:  tx_word = {hdd_data_in[7:0], 8'h00};
      S_STAT_RD: tx_word = {hdd_cmd_req, hdd_dat_req, 14'h0};
      S_DATA_RD: tx_word = words_left ? hdd_data_in : 16'h0;
      default:   tx_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tfr_cnt       <= '0;
      half          <= 1'b0;
      hi_byte       <= '0;
      word_cnt      <= '0;
      load_pend     <= 1'b0;
      tx_sr         <= '0;
      sdo           <= 1'b0;
      hdd_addr      <= '0;
      hdd_data_out  <= '0;
      wr_pend       <= 1'b0;
      stat_pend     <= 1'b0;
      dwr_pend      <= 1'b0;
      rd_pend       <= 1'b0;
      hdd_wr        <= 1'b0;
      hdd_status_wr <= 1'b0;
      hdd_data_wr   <= 1'b0;
      hdd_data_rd   <= 1'b0;
    end else begin
      // data/address settle one clk before their strobe
      wr_pend       <= do_tfr_wr;
      stat_pend     <= do_stat_wr;
      dwr_pend      <= do_word_wr;
      rd_pend       <= do_fifo_rd;
      hdd_wr        <= wr_pend & ~scs_s;
      hdd_status_wr <= stat_pend & ~scs_s;
      hdd_data_wr   <= dwr_pend & ~scs_s;
      hdd_data_rd   <= rd_pend & ~scs_s;

      if (!live) begin
        bit_cnt   <= '0;
        rx_sr     <= '0;
        tfr_cnt   <= '0;
        half      <= 1'b0;
        word_cnt  <= '0;
        load_pend <= 1'b0;
        tx_sr     <= '0;
        sdo       <= 1'b0;
      end else begin
        if (sck_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx_sr   <= rx_byte[6:0];
        end

        if (byte_done && (state == S_TFR_RD || state == S_TFR_WR))
          tfr_cnt <= tfr_cnt + 3'd1;

        if (byte_done && (state == S_DATA_RD || state == S_DATA_WR)) begin
          half <= ~half;
          if (state == S_DATA_WR && !half) hi_byte <= rx_byte;
        end

        if (byte_done && state == S_CMD) begin
          case (rx_byte)
            8'h10:        hdd_addr <= 3'd1;
            8'h13, 8'h14: hdd_addr <= 3'd0;
            default: ;
          endcase
        end

        if (byte_done && state == S_TFR_RD && tfr_cnt != 3'd6)
          hdd_addr <= tfr_cnt + 3'd2;

        if (do_tfr_wr) begin
          hdd_addr     <= tfr_cnt + 3'd1;
          hdd_data_out <= {8'h00, rx_byte};
        end

        if (do_stat_wr)
          hdd_data_out <= {8'h00, rx_byte};

        if (do_word_wr) begin
          hdd_addr     <= 3'd0;
          hdd_data_out <= {hi_byte, rx_byte};
          word_cnt     <= word_cnt + 9'd1;
        end

        if (arm_load)     load_pend <= 1'b1;
        else if (do_load) load_pend <= 1'b0;

        if (do_load) begin
          sdo   <= tx_word[15];
          tx_sr <= {tx_word[14:0], 1'b0};
          if (do_fifo_rd) word_cnt <= word_cnt + 9'd1;
        end else if (do_shift) begin
          sdo   <= tx_sr[15];
          tx_sr <= {tx_sr[14:0], 1'b0};
        end else if (sck_fall) begin
          sdo   <= 1'b0;
          tx_sr <= '0;
        end
      end
    end
  end

endmodule

// File: doc/hdd_spi_host_if.md
Name: hdd_spi_host_if

Overview:
- SPI slave that lets the ARM controller service IDE commands raised by the Gayle IDE block.
- Decodes framed SPI commands. Reads and writes the task-file registers, writes the status/control byte, and streams sector words into or out of the 256x16 sector FIFO.
- Sits between the SPI pins (sck/sdi/sdo/scs) and the Gayle hdd_* port set. Runs entirely in the system clk domain; SPI inputs are oversampled.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sck/sdi/scs (>=2)
- MAX_WORDS, 256, words accepted or produced per data frame

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sck  in  1  SPI clock, mode 0, MSB first, f_sck <= f_clk/8
- sdi  in  1  SPI data from ARM
- sdo  out  1  SPI data to ARM
- scs  in  1  SPI chip select, active low; frame = one low period
- hdd_cmd_req  in  1  Gayle command pending (BSY)
- hdd_dat_req  in  1  Gayle FIFO holds write data for host
- hdd_data_in  in  16  task-file byte in [7:0], or FIFO word when hdd_addr=0
- hdd_addr  out  3  task-file/FIFO select
- hdd_data_out  out  16  data to Gayle
- hdd_wr  out  1  task-file write strobe, 1 clk
- hdd_status_wr  out  1  status write strobe, 1 clk
- hdd_data_wr  out  1  FIFO write strobe, 1 clk
- hdd_data_rd  out  1  FIFO advance strobe, 1 clk

Behaviour:
- Reset (async assert, sync release): state IDLE; all strobes 0; hdd_addr=0; hdd_data_out=0; sdo=0; bit counter 0; word counter 0.
- Edge detection:
  - sck, sdi and scs each pass through SYNC_STAGES flops.
  - Rise and fall of sck are detected from the last two synchronized samples.
  - sdi is sampled on detected rise; sdo is updated on detected fall.
  - scs high forces IDLE within one clk of its synchronized value. Partial bytes, partial words and pending strobes are discarded, and sdo is driven 0.
- First byte of every frame is the command (state CMD). Decode happens on the 8th rise:
  - 0x10 TFR_RD: 7 response bytes = hdd_data_in[7:0] for hdd_addr 1..7. Each byte is latched at the fall after the previous byte's 8th rise. hdd_addr is set >=2 clk before the latch.
  - 0x11 TFR_WR: 7 bytes in. On each 8th rise: hdd_addr = 1..7, hdd_data_out = {8'h00,byte}, then hdd_wr for 1 clk.
  - 0x12 STATUS_WR: 1 byte in. On its 8th rise: hdd_data_out = {8'h00,byte}, then hdd_status_wr for 1 clk.
  - 0x13 DATA_WR: bytes paired high byte first. On each completed word: hdd_addr=0, hdd_data_out=word, then hdd_data_wr for 1 clk. Words beyond MAX_WORDS produce no strobe.
  - 0x14 DATA_RD, with hdd_addr=0:
    - At the start of each 16-bit slot, hdd_data_in is latched into the shift register.
    - hdd_data_rd pulses 1 clk after the latch.
    - The next latch is >=16 sck fall-to-fall later, which covers the FIFO's 2-clk read latency.
    - After MAX_WORDS words: shift 0, no strobe.
  - 0x15 STATUS_RD: 1 response byte = {hdd_cmd_req, hdd_dat_req, 6'b0}, sampled at load time.
  - Any other value: state IGNORE until scs high; no strobes; sdo=0.
- States: IDLE, CMD, TFR_RD, TFR_WR, STAT_WR, DATA_WR, DATA_RD, STAT_RD, IGNORE.
  - IDLE->CMD on scs low.
  - CMD->(decoded state) on 8th rise.
  - TFR_*/STAT_* -> IGNORE after their last byte.
  - DATA_* stay until scs high.
  - Any state -> IDLE on scs high.
- sdo: 0 during the command byte. For read commands, the response MSB is loaded at the fall immediately following the command's 8th rise, then shifted on each fall.
- Only one strobe is asserted in any clk. Strobes occur exactly once per completed byte/word, never on a partial one.
- Word counter: 9 bits, saturates at MAX_WORDS, cleared in IDLE.

Test Plan:
- Frame 0x15 with hdd_cmd_req=1, hdd_dat_req=0 -> second MISO byte 0x80; no strobes.
- Frame 0x11,01,02,..,07 -> seven hdd_wr pulses at hdd_addr 1..7 with hdd_data_out 0x0001..0x0007; no other strobes.
- Frame 0x10 with model task file [1..7]=0xA1..0xA7 -> MISO bytes 0xA1..0xA7 after the command byte.
- Frame 0x13 + 514 bytes (words 0x0000..0x0100) -> exactly 256 hdd_data_wr pulses carrying 0x0000..0x00FF; word 0x0100 produces no strobe.
- Frame 0x14 against a FIFO model preloaded with 0x1234,0xBEEF -> MISO 12 34 BE EF. hdd_data_rd pulses once per word, each 1 clk after its latch.
- Frame 0x12 with scs raised after 5 bits of the data byte -> no hdd_status_wr, state IDLE. Next frame 0x12,0x80 -> one hdd_status_wr with hdd_data_out=0x0080. Async reset asserted mid-frame -> all outputs 0 immediately.
